gf180mcu_fd_sc_mcu7t5v0__xnor_cmp: RTL



---
 rtl/gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_pkg.sv | 12 +
 rtl/gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_satcnt.sv | 16 +
 rtl/gf180mcu_fd_sc_mcu7t5v0__xnor_cmp.sv | 93 +++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_pkg.sv
// gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_pkg: shared constants, group-count helper and parameter legality rule
package gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_pkg;
  localparam int PIPE_MIN = 1;
  localparam int PIPE_MAX = 2;
  function automatic int grp_cnt(input int width, input int grp);
    return width / grp;
  endfunction
  function automatic bit params_ok(input int width, input int pipe, input int grp, input int cnt_w);
    return width >= 2 && width <= 64 && pipe >= PIPE_MIN && pipe <= PIPE_MAX && cnt_w >= 1 &&
           (pipe == PIPE_MIN || (grp >= 1 && width % grp == 0));
  endfunction
endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_satcnt.sv
// gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_satcnt: saturating counter with sync clear and async active-low reset
module gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_satcnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  // clear wins over increment; counting stops at all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor_cmp.sv
// gf180mcu_fd_sc_mcu7t5v0__xnor_cmp: pipelined XNOR compare with all-equal flag and mismatch tracking (optional mask via GF180MCU_FD_SC_MCU7T5V0_XNOR_CMP_MASK_EN)
module gf180mcu_fd_sc_mcu7t5v0__xnor_cmp
  import gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PIPE  = 1,
  parameter int GRP   = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic             CLR,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
`ifdef GF180MCU_FD_SC_MCU7T5V0_XNOR_CMP_MASK_EN
  input  logic [WIDTH-1:0] M,
`endif
  output logic [WIDTH-1:0] ZN,
  output logic             EQ,
  output logic             VLD,
  output logic             STICKY,
  output logic [CNT_W-1:0] MISCNT
);
  logic [WIDTH-1:0] mask, zn_c;
  logic             miss;
  if (!params_ok(WIDTH, PIPE, GRP, CNT_W)) begin : g_bad
    $error("gf180mcu_fd_sc_mcu7t5v0__xnor_cmp: illegal WIDTH/PIPE/GRP/CNT_W");
  end
`ifdef GF180MCU_FD_SC_MCU7T5V0_XNOR_CMP_MASK_EN
  assign mask = M;
`else
  assign mask = '0;
`endif
  assign zn_c = ~(A1 ^ A2) | mask;
  assign miss = VLD && !EQ;
  if (PIPE == PIPE_MIN) begin : g_p1
    // single stage: full reduction in the input cycle
    always_ff @(posedge CLK or negedge RN)
      if (!RN) begin
        ZN  <= '0;
        EQ  <= 1'b0;
        VLD <= 1'b0;
      end else begin
        VLD <= EN;
        if (EN) begin
          ZN <= zn_c;
          EQ <= &zn_c;
        end
      end
  end else begin : g_p2
    localparam int NG = grp_cnt(WIDTH, GRP);
    logic [NG-1:0]    grp_c, grp1;
    logic [WIDTH-1:0] zn1;
    logic             v1;
    for (genvar g = 0; g < NG; g++) begin : g_grp
      assign grp_c[g] = &zn_c[g*GRP +: GRP];
    end
    // stage 1 holds ZN and per-group ANDs, stage 2 finishes the reduction
    always_ff @(posedge CLK or negedge RN)
      if (!RN) begin
        zn1  <= '0;
        grp1 <= '0;
        v1   <= 1'b0;
        ZN   <= '0;
        EQ   <= 1'b0;
        VLD  <= 1'b0;
      end else begin
        v1  <= EN;
        VLD <= v1;
        if (EN) begin
          zn1  <= zn_c;
          grp1 <= grp_c;
        end
        if (v1) begin
          ZN <= zn1;
          EQ <= &grp1;
        end
      end
  end
  // sticky mismatch flag follows the presented result by one cycle; clear has priority
  always_ff @(posedge CLK or negedge RN)
    if (!RN) STICKY <= 1'b0;
    else if (CLR) STICKY <= 1'b0;
    else if (miss) STICKY <= 1'b1;
  gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_satcnt #(.CNT_W(CNT_W)) u_cnt (
    .clk  (CLK),
    .rst_n(RN),
    .clr  (CLR),
    .inc  (miss),
    .cnt  (MISCNT)
  );
endmodule
